// File: rtl/axi_sdram_bist.sv
// axi_sdram_bist
//   AXI4 master that fills an SDRAM region with a pseudo-random pattern in
//   INCR bursts, then reads the region back and checks every beat.
//   The pattern is a 32-bit Galois LFSR (taps 0x8020_0003). It is reseeded
//   at the start of each phase, so the write and read passes see the same
//   sequence.
//
// Ports
//   ACLK, ARSTN        clock, asynchronous active-low reset
//   start              single-cycle start request; ignored while busy
//   busy / done / pass test status; pass is valid while done is high
//   err_count          saturating count of failing beats and write responses
//   first_err_addr     byte address of the first failing beat or burst
//   M_AXI_aw*/w*/b*    write channels; one burst outstanding at a time
//   M_AXI_ar*/r*       read channels; one burst outstanding at a time
//
// Build option
//   AXI_SDRAM_BIST_INVERT_PASS_EN: adds a second write+read pass that uses
//   inverted data, so every cell is checked at both polarities.

module axi_sdram_bist #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          NUM_WORDS = 4096,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic        ACLK,
  input  logic        ARSTN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic        M_AXI_awvalid,
  input  logic        M_AXI_awready,
  output logic [31:0] M_AXI_awaddr,
  output logic [7:0]  M_AXI_awlen,
  output logic [1:0]  M_AXI_awburst,
  output logic [2:0]  M_AXI_awsize,
  output logic        M_AXI_wvalid,
  input  logic        M_AXI_wready,
  output logic [31:0] M_AXI_wdata,
  output logic [3:0]  M_AXI_wstrb,
  output logic        M_AXI_wlast,
  input  logic        M_AXI_bvalid,
  output logic        M_AXI_bready,
  input  logic [1:0]  M_AXI_bresp,
  output logic        M_AXI_arvalid,
  input  logic        M_AXI_arready,
  output logic [31:0] M_AXI_araddr,
  output logic [7:0]  M_AXI_arlen,
  output logic [1:0]  M_AXI_arburst,
  output logic [2:0]  M_AXI_arsize,
  input  logic        M_AXI_rvalid,
  output logic        M_AXI_rready,
  input  logic [31:0] M_AXI_rdata,
  input  logic [1:0]  M_AXI_rresp,
  input  logic        M_AXI_rlast
);

  localparam int              NUM_BURSTS  = NUM_WORDS / BURST_LEN;
  localparam int              IDX_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [31:0]     TAPS        = 32'h8020_0003;
  localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [8:0]      LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [8:0]        beat;
  logic [31:0]       lfsr, lfsr_nxt, pattern, burst_addr, err_addr;
  logic              beat_last, idx_last, err_hit;

  assign lfsr_nxt   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
  assign beat_last  = (beat == LAST_BEAT);
  assign idx_last   = (idx == LAST_IDX);
  assign burst_addr = ADDR_BASE + 32'(idx) * BURST_BYTES;

`ifdef AXI_SDRAM_BIST_INVERT_PASS_EN
  logic inv_pass;
  assign pattern = inv_pass ? ~lfsr : lfsr;
`else
  assign pattern = lfsr;
`endif

  assign M_AXI_awaddr  = burst_addr;
  assign M_AXI_araddr  = burst_addr;
  assign M_AXI_awlen   = 8'(BURST_LEN - 1);
  assign M_AXI_arlen   = 8'(BURST_LEN - 1);
  assign M_AXI_awburst = 2'b01;
  assign M_AXI_arburst = 2'b01;
  assign M_AXI_awsize  = 3'b010;
  assign M_AXI_arsize  = 3'b010;
  assign M_AXI_wstrb   = 4'hF;
  assign M_AXI_wdata   = pattern;
  assign M_AXI_wlast   = (state == WR_DATA) && beat_last;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'h0);

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_bready  = 1'b0;
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = WR_ADDR;
      WR_ADDR: begin
        M_AXI_awvalid = 1'b1;
        if (M_AXI_awready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        M_AXI_wvalid = 1'b1;
        if (M_AXI_wready && beat_last) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_bready = 1'b1;
        if (M_AXI_bvalid) state_nxt = idx_last ? RD_ADDR : WR_ADDR;
      end
      RD_ADDR: begin
        M_AXI_arvalid = 1'b1;
        if (M_AXI_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_rready = 1'b1;
        if (M_AXI_rvalid && beat_last) begin
          if (!idx_last) state_nxt = RD_ADDR;
`ifdef AXI_SDRAM_BIST_INVERT_PASS_EN
          else           state_nxt = inv_pass ? DONE : WR_ADDR;
`else
          else           state_nxt = DONE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A write burst fails on a non-OKAY response; a read beat fails on data,
  // response or a misplaced rlast.
  always_comb begin
    err_hit  = 1'b0;
    err_addr = burst_addr;
    if (state == WR_RESP && M_AXI_bvalid && M_AXI_bresp != 2'b00) begin
      err_hit = 1'b1;
    end else if (state == RD_DATA && M_AXI_rvalid) begin
      err_addr = burst_addr + (32'(beat) << 2);
      err_hit  = (M_AXI_rdata != pattern) || (M_AXI_rresp != 2'b00) ||
                 (M_AXI_rlast != beat_last);
    end
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      idx            <= '0;
      beat           <= '0;
      lfsr           <= SEED;
      err_count      <= '0;
      first_err_addr <= '0;
`ifdef AXI_SDRAM_BIST_INVERT_PASS_EN
      inv_pass       <= 1'b0;
`endif
    end else begin
      if (err_hit) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'h0)    first_err_addr <= err_addr;
      end
      case (state)
        IDLE, DONE: if (start) begin
          idx            <= '0;
          beat           <= '0;
          lfsr           <= SEED;
          err_count      <= '0;
          first_err_addr <= '0;
`ifdef AXI_SDRAM_BIST_INVERT_PASS_EN
          inv_pass       <= 1'b0;
`endif
        end
        WR_DATA: if (M_AXI_wready) begin
          lfsr <= lfsr_nxt;
          beat <= beat_last ? 9'd0 : beat + 9'd1;
        end
        WR_RESP: if (M_AXI_bvalid) begin
          if (idx_last) begin
            idx  <= '0;
            lfsr <= SEED;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RD_DATA: if (M_AXI_rvalid) begin
          lfsr <= lfsr_nxt;
          beat <= beat_last ? 9'd0 : beat + 9'd1;
          if (beat_last) begin
            if (idx_last) begin
              idx  <= '0;
              lfsr <= SEED;
`ifdef AXI_SDRAM_BIST_INVERT_PASS_EN
              inv_pass <= 1'b1;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sdram_bist.sv
// Testbench for axi_sdram_bist: a small AXI slave memory model with optional
// stalls, a corrupted read word and an error write response. Expected
// addresses and write data are queued when a run is started and popped as the
// DUT produces handshakes.

module tb_axi_sdram_bist;

  localparam int          NW     = 64;
  localparam int          BL     = 16;
  localparam int          NB     = NW / BL;
  localparam logic [31:0] SEED_V = 32'hACE1_2468;
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  logic        ACLK = 1'b0;
  logic        ARSTN = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [2:0]  awsize, arsize;
  logic [3:0]  wstrb;

  always #5 ACLK = ~ACLK;

  axi_sdram_bist #(
    .ADDR_BASE(32'h0), .NUM_WORDS(NW), .BURST_LEN(BL), .SEED(SEED_V)
  ) dut (
    .ACLK(ACLK), .ARSTN(ARSTN), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .M_AXI_awvalid(awvalid), .M_AXI_awready(awready), .M_AXI_awaddr(awaddr),
    .M_AXI_awlen(awlen), .M_AXI_awburst(awburst), .M_AXI_awsize(awsize),
    .M_AXI_wvalid(wvalid), .M_AXI_wready(wready), .M_AXI_wdata(wdata),
    .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast),
    .M_AXI_bvalid(bvalid), .M_AXI_bready(bready), .M_AXI_bresp(bresp),
    .M_AXI_arvalid(arvalid), .M_AXI_arready(arready), .M_AXI_araddr(araddr),
    .M_AXI_arlen(arlen), .M_AXI_arburst(arburst), .M_AXI_arsize(arsize),
    .M_AXI_rvalid(rvalid), .M_AXI_rready(rready), .M_AXI_rdata(rdata),
    .M_AXI_rresp(rresp), .M_AXI_rlast(rlast)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] mem [0:NW-1];

  bit          stall_en, flip_en;
  int          bad_b_burst;
  int          aw_cnt, ar_cnt, b_cnt, w_beat, r_beat;
  bit          aw_pend, b_pend, ar_pend;
  logic [5:0]  wptr, rptr;
  bit          prev_aw_stall, prev_w_stall;
  logic [31:0] prev_awaddr, prev_wdata;

  function automatic bit rnd_ready();
    return !stall_en || ($urandom_range(0, 1) == 1);
  endfunction

  // Slave model: sample handshakes at the clock edge, drive responses 1 ns later.
  initial begin
    logic [31:0] e;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(posedge ACLK);
      if (!ARSTN) begin
        aw_pend = 0; b_pend = 0; ar_pend = 0; w_beat = 0; r_beat = 0;
        prev_aw_stall = 0; prev_w_stall = 0;
      end else begin
        if (prev_aw_stall) begin
          check("aw_hold_valid", 32'(awvalid), 32'd1);
          check("aw_hold_addr", awaddr, prev_awaddr);
        end
        if (prev_w_stall) begin
          check("w_hold_valid", 32'(wvalid), 32'd1);
          check("w_hold_data", wdata, prev_wdata);
        end
        prev_aw_stall = awvalid && !awready;
        prev_awaddr   = awaddr;
        prev_w_stall  = wvalid && !wready;
        prev_wdata    = wdata;
        if (wvalid) check("w_before_aw", 32'(aw_pend), 32'd1);

        if (awvalid && awready) begin
          aw_cnt++;
          e = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : 32'hDEAD_BEEF;
          check("awaddr", awaddr, e);
          check("aw_fields", {awlen, 6'd0, awburst, 5'd0, awsize, 4'd0, wstrb},
                {8'(BL - 1), 6'd0, 2'b01, 5'd0, 3'b010, 4'd0, 4'hF});
          aw_pend = 1; wptr = awaddr[7:2]; w_beat = 0;
        end
        if (wvalid && wready) begin
          e = (exp_wd_q.size() > 0) ? exp_wd_q.pop_front() : 32'hDEAD_BEEF;
          check("wdata", wdata, e);
          check("wlast", 32'(wlast), 32'(w_beat == BL - 1));
          mem[wptr] = wdata;
          wptr++;
          w_beat++;
          if (w_beat == BL) begin
            aw_pend = 0; b_pend = 1; w_beat = 0;
          end
        end
        if (bvalid && bready) begin
          b_pend = 0; b_cnt++;
        end
        if (arvalid && arready) begin
          ar_cnt++;
          e = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : 32'hDEAD_BEEF;
          check("araddr", araddr, e);
          check("ar_fields", {arlen, 6'd0, arburst, 5'd0, arsize},
                {8'(BL - 1), 6'd0, 2'b01, 5'd0, 3'b010});
          ar_pend = 1; rptr = araddr[7:2]; r_beat = 0;
        end
        if (rvalid && rready) begin
          rptr++;
          r_beat++;
          if (r_beat == BL) ar_pend = 0;
        end
      end
      #1;
      awready = rnd_ready();
      wready  = aw_pend && rnd_ready();
      bvalid  = b_pend;
      bresp   = (b_pend && b_cnt == bad_b_burst) ? 2'b10 : 2'b00;
      arready = rnd_ready();
      rvalid  = ar_pend && rnd_ready();
      rdata   = mem[rptr] ^ ((flip_en && rptr == 6'd33) ? 32'h1 : 32'h0);
      rlast   = (r_beat == BL - 1);
      rresp   = 2'b00;
    end
  end

  task automatic setup(input bit st, input bit fl, input int badb);
    logic [31:0] s;
    stall_en = st; flip_en = fl; bad_b_burst = badb;
    aw_cnt = 0; ar_cnt = 0; b_cnt = 0;
    exp_aw_q.delete(); exp_ar_q.delete(); exp_wd_q.delete();
    for (int i = 0; i < NB; i++) begin
      exp_aw_q.push_back(32'(i * BL * 4));
      exp_ar_q.push_back(32'(i * BL * 4));
    end
    s = SEED_V;
    for (int i = 0; i < NW; i++) begin
      exp_wd_q.push_back(s);
      s = lfsr_step(s);
    end
  endtask

  task automatic pulse_start();
    @(posedge ACLK); #1 start = 1;
    @(posedge ACLK); #1 start = 0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 5000), 32'd1);
  endtask

  task automatic check_result(input string tag, input bit exp_pass, input int exp_err,
                              input logic [31:0] exp_first);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, "_first_err"}, first_err_addr, exp_first);
    check({tag, "_aw_cnt"}, 32'(aw_cnt), 32'(NB));
    check({tag, "_ar_cnt"}, 32'(ar_cnt), 32'(NB));
    check({tag, "_q_left"}, 32'(exp_aw_q.size() + exp_ar_q.size() + exp_wd_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    setup(0, 0, -1);
    repeat (3) @(posedge ACLK);
    #1;
    check_idle_outputs("reset");
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_first_err", first_err_addr, 32'd0);
    ARSTN = 1;

    setup(0, 0, -1);
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("basic");
    check_result("basic", 1, 0, 32'h0);

    setup(0, 1, -1);
    pulse_start();
    wait_done("flip");
    check_result("flip", 0, 1, 32'h84);

    setup(1, 0, -1);
    pulse_start();
    wait_done("stall");
    check_result("stall", 1, 0, 32'h0);

    setup(0, 0, 1);
    pulse_start();
    wait_done("bresp");
    check_result("bresp", 0, 1, 32'h40);

    setup(0, 0, -1);
    pulse_start();
    cyc = 0;
    while (!wvalid && cyc < 200) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    check("rst_reach_wdata", 32'(wvalid), 32'd1);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARSTN = 0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge ACLK);
    #1 ARSTN = 1;
    setup(0, 0, -1);
    pulse_start();
    wait_done("rerun");
    check_result("rerun", 1, 0, 32'h0);

    setup(0, 0, -1);
    pulse_start();
    repeat (5) @(posedge ACLK);
    #1 start = 1;
    @(posedge ACLK); #1 start = 0;
    repeat (40) @(posedge ACLK);
    #1 start = 1;
    @(posedge ACLK); #1 start = 0;
    wait_done("busy_start");
    check_result("busy_start", 1, 0, 32'h0);
    repeat (5) @(posedge ACLK);
    #1;
    check("done_held", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
